// File: rtl/mem_port_arbiter.sv
// Shares the single physical memory port between the instruction-fetch side
// and the load/store data side. Simultaneous requests are resolved
// round-robin. The winning request is latched and driven to memory until the
// response arrives or the wait timeout aborts it.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [31:0]       i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_byte_enable,
  output logic [31:0]       d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [31:0]       pmem_wdata,
  output logic [3:0]        pmem_byte_enable,
  input  logic [31:0]       pmem_rdata,
  input  logic              pmem_resp,
  output logic              timeout_err
);

  // A zero TIMEOUT disables the abort, but the counter still needs one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic TIMEOUT_EN = (TIMEOUT > 0);
  // Returned on an aborted read so a stuck fetch executes as a NOP.
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              is_write;
  logic [CNT_W-1:0]  cnt;

  logic              d_req;
  logic              grant_i;
  logic              grant_d;
  logic              serving;
  logic              abort;
  logic              done;
  logic [31:0]       rdata_sel;

  // last_grant = 1 means D was served last, so I wins the next conflict.
  assign d_req   = d_read | d_write;
  assign grant_i = (state == IDLE) && i_read && (!d_req || last_grant);
  assign grant_d = (state == IDLE) && d_req && (!i_read || !last_grant);
  assign serving = (state != IDLE);
  // A response arriving on the abort cycle wins: it completes normally.
  assign abort   = TIMEOUT_EN && serving && !pmem_resp && (cnt == CNT_LAST);
  assign done    = serving && (pmem_resp || abort);
  assign rdata_sel = pmem_resp ? pmem_rdata : NOP;

  assign pmem_address     = addr;
  assign pmem_wdata       = wdata;
  assign pmem_byte_enable = be;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE on completion or abort.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_next = SERVE_I;
        end else if (grant_d) begin
          state_next = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: memory commands from latched request, response routed to the owner.
  always_comb begin
    pmem_read   = serving && !is_write;
    pmem_write  = serving && is_write;
    timeout_err = abort;
    i_resp      = 1'b0;
    i_rdata     = '0;
    d_resp      = 1'b0;
    d_rdata     = '0;
    if (state == SERVE_I && done) begin
      i_resp  = 1'b1;
      i_rdata = rdata_sel;
    end
    if (state == SERVE_D && done) begin
      d_resp  = 1'b1;
      d_rdata = rdata_sel;
    end
  end

  // Latch the winning request; a data-side read+write is treated as a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= 1'b1;
      addr       <= '0;
      wdata      <= '0;
      be         <= '0;
      is_write   <= 1'b0;
    end else if (grant_i) begin
      last_grant <= 1'b0;
      addr       <= i_address;
      wdata      <= '0;
      be         <= 4'b1111;
      is_write   <= 1'b0;
    end else if (grant_d) begin
      last_grant <= 1'b1;
      addr       <= d_address;
      wdata      <= d_wdata;
      be         <= d_byte_enable;
      is_write   <= d_write;
    end
  end

  // Wait counter: counts unanswered serve cycles, cleared when a transaction ends.
  always_ff @(posedge clk) begin
    if (!rst || done || !serving) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_read = 1'b0;
  logic [31:0] i_address = '0;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_address = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_byte_enable = '0;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, what was latched, and the
  // cycle number of the grant. Cycle numbers advance on each rising edge.
  int          cyc = 0;
  int          m_side = 0;   // 0 none, 1 instruction, 2 data
  int          m_last = 1;   // 0 I served last, 1 D served last
  int          m_gcyc = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic        m_wr = 1'b0;
  logic        armed = 1'b0;

  logic        e_pr = 1'b0, e_pw = 1'b0, e_ir = 1'b0, e_dr = 1'b0, e_to = 1'b0;
  logic [31:0] e_ird = '0, e_drd = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      m_side <= 0; m_last <= 1; m_addr <= '0; m_wdata <= '0; m_be <= '0; m_wr <= 1'b0;
      armed <= 1'b1;
    end else if (m_side == 0) begin
      if (i_read && (!(d_read || d_write) || m_last == 1)) begin
        m_side <= 1; m_last <= 0; m_addr <= i_address; m_wdata <= '0;
        m_be <= 4'hF; m_wr <= 1'b0; m_gcyc <= cyc;
      end else if (d_read || d_write) begin
        m_side <= 2; m_last <= 1; m_addr <= d_address; m_wdata <= d_wdata;
        m_be <= d_byte_enable; m_wr <= d_write; m_gcyc <= cyc;
      end
    end else if (e_ir || e_dr) begin
      m_side <= 0;
    end
  end

  // Compare process: evaluate expected outputs mid-cycle and check every output.
  always @(negedge clk) begin
    logic serve, abort, fin;
    logic [31:0] val;
    #2;
    serve = (m_side != 0);
    abort = serve && !pmem_resp && (TO != 0) && (cyc - m_gcyc == TO);
    fin   = serve && (pmem_resp || abort);
    val   = pmem_resp ? pmem_rdata : 32'h0000_0013;
    e_pr  = serve && !m_wr;
    e_pw  = serve && m_wr;
    e_to  = abort;
    e_ir  = fin && (m_side == 1);
    e_dr  = fin && (m_side == 2);
    e_ird = e_ir ? val : 32'h0;
    e_drd = e_dr ? val : 32'h0;
    if (armed) begin
      chk("pmem_read", pmem_read, e_pr);
      chk("pmem_write", pmem_write, e_pw);
      chk("pmem_address", pmem_address, m_addr);
      chk("pmem_wdata", pmem_wdata, m_wdata);
      chk("pmem_byte_enable", pmem_byte_enable, m_be);
      chk("i_resp", i_resp, e_ir);
      chk("i_rdata", i_rdata, e_ird);
      chk("d_resp", d_resp, e_dr);
      chk("d_rdata", d_rdata, e_drd);
      chk("timeout_err", timeout_err, e_to);
    end
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    int kind;
    // Reset
    next_cycle();
    next_cycle(); settle();
    chk("lit_rst_pmem_read", pmem_read, 1'b0);
    chk("lit_rst_i_resp", i_resp, 1'b0);
    chk("lit_rst_addr", pmem_address, 32'h0);
    rst = 1'b1;

    // Solo I read of 0x60, memory answers 3 cycles after pmem_read rises
    next_cycle(); i_read = 1'b1; i_address = 32'h60;
    next_cycle(); settle();
    chk("lit_solo_i_pmem_read", pmem_read, 1'b1);
    chk("lit_solo_i_addr", pmem_address, 32'h60);
    next_cycle();
    next_cycle();
    next_cycle(); pmem_resp = 1'b1; pmem_rdata = 32'h0000_0513; settle();
    chk("lit_solo_i_resp", i_resp, 1'b1);
    chk("lit_solo_i_rdata", i_rdata, 32'h0000_0513);
    chk("lit_solo_i_dresp", d_resp, 1'b0);
    next_cycle(); i_read = 1'b0; pmem_resp = 1'b0; settle();
    chk("lit_solo_i_resp_drop", i_resp, 1'b0);

    // D write held stable even when the requester's inputs change
    next_cycle(); d_write = 1'b1; d_address = 32'h100; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
    next_cycle(); d_address = 32'h200; d_wdata = 32'h0; d_byte_enable = 4'b1100; settle();
    chk("lit_dw_pmem_write", pmem_write, 1'b1);
    chk("lit_dw_addr", pmem_address, 32'h100);
    chk("lit_dw_wdata", pmem_wdata, 32'hDEADBEEF);
    chk("lit_dw_be", pmem_byte_enable, 4'b0011);
    next_cycle(); pmem_resp = 1'b1; settle();
    chk("lit_dw_dresp", d_resp, 1'b1);
    next_cycle(); d_write = 1'b0; pmem_resp = 1'b0; settle();
    chk("lit_dw_dresp_drop", d_resp, 1'b0);

    // Conflict after a D transaction: I first, D two cycles after i_resp
    next_cycle(); i_read = 1'b1; i_address = 32'h40; d_read = 1'b1; d_address = 32'h80;
    next_cycle(); pmem_resp = 1'b1; pmem_rdata = 32'h11; settle();
    chk("lit_cf1_addr_i", pmem_address, 32'h40);
    chk("lit_cf1_iresp", i_resp, 1'b1);
    next_cycle(); i_read = 1'b0; pmem_resp = 1'b0; settle();
    chk("lit_cf1_bubble", pmem_read, 1'b0);
    next_cycle(); pmem_resp = 1'b1; settle();
    chk("lit_cf1_addr_d", pmem_address, 32'h80);
    chk("lit_cf1_dresp", d_resp, 1'b1);
    next_cycle(); d_read = 1'b0; pmem_resp = 1'b0;

    // Solo I, then conflict: D goes first
    next_cycle(); i_read = 1'b1; i_address = 32'h44;
    next_cycle(); pmem_resp = 1'b1;
    next_cycle(); i_read = 1'b0; pmem_resp = 1'b0;
    next_cycle(); i_read = 1'b1; i_address = 32'h48; d_read = 1'b1; d_address = 32'h88;
    next_cycle(); pmem_resp = 1'b1; settle();
    chk("lit_cf2_addr_d", pmem_address, 32'h88);
    chk("lit_cf2_dresp", d_resp, 1'b1);
    next_cycle(); d_read = 1'b0; pmem_resp = 1'b0;
    next_cycle(); pmem_resp = 1'b1; settle();
    chk("lit_cf2_addr_i", pmem_address, 32'h48);
    next_cycle(); i_read = 1'b0; pmem_resp = 1'b0;

    // Timeout on a D read, then a normal I read
    next_cycle(); d_read = 1'b1; d_address = 32'h300;
    for (int k = 1; k < TO; k++) begin
      next_cycle(); settle();
      chk("lit_to_early", timeout_err, 1'b0);
    end
    next_cycle(); settle();
    chk("lit_to_err", timeout_err, 1'b1);
    chk("lit_to_dresp", d_resp, 1'b1);
    chk("lit_to_nop", d_rdata, 32'h0000_0013);
    next_cycle(); d_read = 1'b0; i_read = 1'b1; i_address = 32'h400;
    next_cycle(); pmem_resp = 1'b1; pmem_rdata = 32'h77; settle();
    chk("lit_to_after_addr", pmem_address, 32'h400);
    chk("lit_to_after_rdata", i_rdata, 32'h77);
    next_cycle(); i_read = 1'b0; pmem_resp = 1'b0;

    // Reset during an I wait; afterwards a conflict goes to I
    next_cycle(); i_read = 1'b1; i_address = 32'h500;
    next_cycle(); settle();
    chk("lit_rs_pmem_read", pmem_read, 1'b1);
    next_cycle(); rst = 1'b0;
    next_cycle(); rst = 1'b1; d_read = 1'b1; d_address = 32'h600; pmem_resp = 1'b1; pmem_rdata = 32'hAA; settle();
    chk("lit_rs_read_gone", pmem_read, 1'b0);
    chk("lit_rs_no_iresp", i_resp, 1'b0);
    chk("lit_rs_no_to", timeout_err, 1'b0);
    next_cycle(); settle();
    chk("lit_rs_addr_i", pmem_address, 32'h500);
    chk("lit_rs_iresp", i_resp, 1'b1);
    next_cycle(); i_read = 1'b0; pmem_resp = 1'b0;
    next_cycle(); pmem_resp = 1'b1; settle();
    chk("lit_rs_addr_d", pmem_address, 32'h600);
    chk("lit_rs_dresp", d_resp, 1'b1);
    next_cycle(); d_read = 1'b0; pmem_resp = 1'b0;

    // Randomized traffic: requesters hold until resp and drop the cycle after
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      rst = ($urandom_range(0, 399) != 0);
      if (e_ir) i_read = 1'b0;
      else if (!i_read && $urandom_range(0, 2) == 0) i_read = 1'b1;
      i_address = $urandom;
      if (e_dr) begin
        d_read = 1'b0; d_write = 1'b0;
      end else if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 3);
        d_read  = (kind != 1);
        d_write = (kind == 1) || (kind == 2);
      end
      d_address     = $urandom;
      d_wdata       = $urandom;
      d_byte_enable = 4'($urandom);
      pmem_resp     = ($urandom_range(0, 4) == 0);
      pmem_rdata    = $urandom;
    end

    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single physical memory port between the instruction-fetch side and the load/store data side of the RV32I core. Each side uses the same hold-until-`resp` read/write handshake the control FSM already uses toward memory. The arbiter registers the winning request, drives it to memory, and routes the response back. It resolves simultaneous requests round-robin and aborts hung transactions with a programmable timeout.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles a granted transaction may wait for `pmem_resp` before abort. 0 disables the timeout.
- `ADDR_W`, 32: address width.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `i_read`  in  1  instruction-side read request. Held high until `i_resp`.
- `i_address`  in  ADDR_W  instruction-side address.
- `i_rdata`  out  32  instruction-side read data. Valid only while `i_resp`=1.
- `i_resp`  out  1  instruction-side completion pulse.
- `d_read`  in  1  data-side read request.
- `d_write`  in  1  data-side write request.
- `d_address`  in  ADDR_W  data-side address.
- `d_wdata`  in  32  data-side write data.
- `d_byte_enable`  in  4  data-side write byte mask.
- `d_rdata`  out  32  data-side read data. Valid only while `d_resp`=1.
- `d_resp`  out  1  data-side completion pulse.
- `pmem_read`, `pmem_write`  out  1 each  physical memory commands.
- `pmem_address`  out  ADDR_W  physical memory address.
- `pmem_wdata`  out  32  physical memory write data.
- `pmem_byte_enable`  out  4  physical memory byte mask.
- `pmem_rdata`  in  32  physical memory read data.
- `pmem_resp`  in  1  physical memory completion.
- `timeout_err`  out  1  one-cycle pulse when a transaction is aborted.

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`.
- Registers:
  - `last_grant`: 0=I, 1=D.
  - Latched `addr`, `wdata`, `be`, and `is_write`.
  - Wait counter, width clog2(TIMEOUT+1).
- `IDLE`:
  - Sample the requests. `d_req` = `d_read` | `d_write`.
  - Only I requests: go to `SERVE_I`.
  - Only D requests: go to `SERVE_D`.
  - Both request: grant the side that is not `last_grant`.
  - On a grant, latch the winner's address, wdata and byte_enable, and update `last_grant`.
  - For I: `is_write`=0 and `be`=4'b1111.
  - If `d_read` and `d_write` are both high, the data side is treated as a write.
- `SERVE_x`:
  - `pmem_read` = !is_write and `pmem_write` = is_write, both driven from the latched registers.
  - `pmem_address`/`pmem_wdata`/`pmem_byte_enable` come from the latched registers and stay stable for the whole transaction.
  - On `pmem_resp`=1: assert `x_resp` combinationally in the same cycle, pass `pmem_rdata` to `x_rdata`, then go to `IDLE`.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT-1 with no response, the cycle is an abort:
    - pulse `timeout_err` and `x_resp`;
    - drive `x_rdata` = 32'h0000_0013 (NOP), so a stuck fetch does not wedge the core;
    - go to `IDLE`.
- The wait counter clears on entry to `IDLE`.
- The non-granted side sees `resp`=0 and `rdata`=0. Its request simply stays pending.
- Requesters must drop the request in the cycle after `resp`. The control FSM already does this.
- Outputs in `IDLE`: all `pmem_*` commands, both `resp`s, both `rdata`s and `timeout_err` are 0. `pmem_address`/`wdata`/`be` hold their last latched values.

## Timing
- Reset (`rst`=0 at an edge): state=`IDLE`, `last_grant`=1 (D), so I wins the first conflict. Latched registers and counter are 0.
  - Every output is 0 from the first cycle after that edge.
  - Reset mid-transaction abandons the transaction silently: no `resp` and no `timeout_err`.
- Request seen in `IDLE` at cycle 0: `pmem_read`/`pmem_write` high from cycle 1.
- `pmem_resp` in cycle k: `x_resp` in cycle k. `IDLE` in cycle k+1. Next grant at the earliest in cycle k+1, with `pmem_*` active in cycle k+2.
  - This gives exactly one bubble cycle between back-to-back transactions.
- Minimum transaction with zero-wait memory (`pmem_resp` in cycle 1): 2 cycles, request to `resp`.
- Timeout: with no `pmem_resp`, abort occurs in cycle TIMEOUT after the grant edge.
- `pmem_resp` in the same cycle as the abort condition: treated as a normal completion, with no `timeout_err`.
- `pmem_resp` while in `IDLE` is ignored.
- Request changes during `SERVE` have no effect, because the values are latched.

## Test plan
- Solo I read of 0x0000_0060, memory responds 3 cycles after `pmem_read` rises, `pmem_rdata`=0x0000_0513 -> `pmem_read` high from cycle 1, `i_resp`=1 with `i_rdata`=0x0000_0513 in cycle 4, `d_resp` stays 0.
- D write of addr 0x100, wdata 0xDEADBEEF, be 4'b0011 -> `pmem_write`=1 with the same address/data/mask held constant until `pmem_resp`, then `d_resp` pulses for one cycle.
- I and D request in the same cycle after reset -> I is served first; D is served with `pmem_*` active two cycles after `i_resp`. Repeat the conflict -> D is served first.
- Continuous I and D requests for 8 transactions -> grants strictly alternate I, D, I, D…, with one `IDLE` bubble between transactions.
- TIMEOUT=8, D read with `pmem_resp` never asserted -> `timeout_err` and `d_resp` pulse in cycle 8 after the grant, `d_rdata`=0x0000_0013; a following I request is served normally.
- `rst`=0 asserted in the middle of a `SERVE_I` wait -> `pmem_read`=0 and no `resp` from the next cycle; after release, a conflicting request goes to I first.
